// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: request side drives start and operands,
// the subtractor answers with busy/done and the registered difference and borrow.
`timescale 1ns/1ps
interface serial_ripple_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (output start, a, b, bin, input busy, done, d, bout);
    modport slave  (input start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first, one full-subtractor cell; done WIDTH edges after start.
// No backpressure: start is taken in IDLE or DONE and ignored while busy.
`timescale 1ns/1ps
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_ripple_subtractor_if.slave   sub
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] d_q;
    logic             br;
    logic             br_nxt;
    logic             bout_q;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             a0;
    logic             b0;
    logic             diff;

    assign a0      = sh_a[0];
    assign b0      = sh_b[0];
    assign diff    = a0 ^ b0 ^ br;
    assign br_nxt  = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign res_nxt = {diff, res[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (sub.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A waiting request chains straight into the next operation.
                if (sub.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            sh_a <= sub.a;
            sh_b <= sub.b;
            br   <= sub.bin;
            res  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            br   <= br_nxt;
            res  <= res_nxt;
            cnt  <= cnt + CW'(1);
            // Outputs only move on the final bit so a partial result is never visible.
            if (last) begin
                d_q    <= res_nxt;
                bout_q <= br_nxt;
            end
        end
    end

    assign sub.busy = (state == RUN);
    assign sub.done = (state == DONE);
    assign sub.d    = d_q;
    assign sub.bout = bout_q;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: directed table, handshake corner cases, reset abort,
// exhaustive 4-bit sweep and random 8-bit operations against an arithmetic reference.
`timescale 1ns/1ps
module tb_serial_ripple_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_ripple_subtractor_if #(.WIDTH(4)) s4 ();
    serial_ripple_subtractor_if #(.WIDTH(8)) s8 ();

    serial_ripple_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .sub(s4.slave));
    serial_ripple_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .sub(s8.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl4", 32'(s4.busy & s4.done), 32'd0);
            check("busy_done_excl8", 32'(s8.busy & s8.done), 32'd0);
        end
    end

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] prev_d,
                        output logic [3:0] got_d, output logic got_bout, output int lat);
        s4.start = 1'b1; s4.a = a; s4.b = b; s4.bin = bin;
        @(posedge clk); #1;
        s4.start = 1'b0;
        lat = 0;
        while (!s4.done && lat < 20) begin
            check("busy_in_run4", 32'(s4.busy), 32'd1);
            check("d_held4", 32'(s4.d), 32'(prev_d));
            @(posedge clk); #1;
            lat++;
        end
        got_d = s4.d; got_bout = s4.bout;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] prev_d,
                        output logic [7:0] got_d, output logic got_bout, output int lat);
        s8.start = 1'b1; s8.a = a; s8.b = b; s8.bin = bin;
        @(posedge clk); #1;
        s8.start = 1'b0;
        lat = 0;
        while (!s8.done && lat < 30) begin
            check("d_held8", 32'(s8.d), 32'(prev_d));
            @(posedge clk); #1;
            lat++;
        end
        got_d = s8.d; got_bout = s8.bout;
    endtask

    initial begin
        logic [3:0] gd4;
        logic [7:0] gd8;
        logic       gb;
        int         lat;
        int         r;
        logic [3:0] prev4;
        logic [7:0] prev8;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        vecs[0] = '{4'd0,  4'd0,  1'b0, 4'b0000, 1'b0};
        vecs[1] = '{4'd7,  4'd3,  1'b0, 4'b0100, 1'b0};
        vecs[2] = '{4'd3,  4'd4,  1'b0, 4'b1111, 1'b1};
        vecs[3] = '{4'd0,  4'd0,  1'b1, 4'b1111, 1'b1};
        vecs[4] = '{4'd15, 4'd15, 1'b1, 4'b1111, 1'b1};
        vecs[5] = '{4'd12, 4'd7,  1'b1, 4'b0100, 1'b0};
        vecs[6] = '{4'd8,  4'd1,  1'b0, 4'b0111, 1'b0};

        rst_n = 1'b0;
        s4.start = 1'b0; s4.a = '0; s4.b = '0; s4.bin = 1'b0;
        s8.start = 1'b0; s8.a = '0; s8.b = '0; s8.bin = 1'b0;
        #1;
        check("rst_busy", 32'(s4.busy), 32'd0);
        check("rst_done", 32'(s4.done), 32'd0);
        check("rst_d",    32'(s4.d),    32'd0);
        check("rst_bout", 32'(s4.bout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        prev4 = 4'd0;
        for (int i = 0; i < 7; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].bin, prev4, gd4, gb, lat);
            check("tbl_lat",  32'(lat), 32'd4);
            check("tbl_d",    32'(gd4), 32'(vecs[i].d));
            check("tbl_bout", 32'(gb),  32'(vecs[i].bout));
            prev4 = vecs[i].d;
        end
        @(posedge clk); #1;

        // Start pulsed mid-run with different operands must be ignored.
        s4.start = 1'b1; s4.a = 4'd7; s4.b = 4'd3; s4.bin = 1'b0;
        @(posedge clk); #1;
        s4.start = 1'b0;
        @(posedge clk); #1;
        s4.start = 1'b1; s4.a = 4'd1; s4.b = 4'd9; s4.bin = 1'b1;
        @(posedge clk); #1;
        s4.start = 1'b0;
        @(posedge clk); #1;
        check("ign_not_done_yet", 32'(s4.done), 32'd0);
        @(posedge clk); #1;
        check("ign_done", 32'(s4.done), 32'd1);
        check("ign_d",    32'(s4.d),    32'd4);
        check("ign_bout", 32'(s4.bout), 32'd0);
        @(posedge clk); #1;
        check("ign_idle_busy", 32'(s4.busy), 32'd0);
        check("ign_idle_done", 32'(s4.done), 32'd0);

        // Start held high: the second operation chains from DONE, done every 5 cycles.
        s4.start = 1'b1; s4.a = 4'd5; s4.b = 4'd2; s4.bin = 1'b0;
        @(posedge clk); #1;
        s4.a = 4'd9; s4.b = 4'd4; s4.bin = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            if (e == 4) begin
                check("b2b_done1", 32'(s4.done), 32'd1);
                check("b2b_d1",    32'(s4.d),    32'd3);
            end else if (e == 9) begin
                check("b2b_done2", 32'(s4.done), 32'd1);
                check("b2b_d2",    32'(s4.d),    32'd4);
                check("b2b_bout2", 32'(s4.bout), 32'd0);
            end else begin
                check("b2b_no_done", 32'(s4.done), 32'd0);
            end
        end
        s4.start = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 32'(s4.busy | s4.done), 32'd0);

        // Reset mid-run abandons the operation and clears outputs without a clock.
        s4.start = 1'b1; s4.a = 4'd14; s4.b = 4'd3; s4.bin = 1'b0;
        @(posedge clk); #1;
        s4.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(s4.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(s4.busy), 32'd0);
        check("abort_done", 32'(s4.done), 32'd0);
        check("abort_d",    32'(s4.d),    32'd0);
        check("abort_bout", 32'(s4.bout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(s4.done), 32'd0);
        end
        run4(4'd9, 4'd2, 1'b0, 4'd0, gd4, gb, lat);
        check("post_rst_d",    32'(gd4), 32'd7);
        check("post_rst_bout", 32'(gb),  32'd0);
        check("post_rst_lat",  32'(lat), 32'd4);
        prev4 = 4'd7;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    r = a - b - c;
                    run4(4'(a), 4'(b), 1'(c), prev4, gd4, gb, lat);
                    check("sweep_d",    32'(gd4), 32'(r[3:0]));
                    check("sweep_bout", 32'(gb),  32'(r < 0));
                    check("sweep_lat",  32'(lat), 32'd4);
                    prev4 = r[3:0];
                end
            end
        end

        prev8 = 8'd0;
        run8(8'h00, 8'h01, 1'b0, prev8, gd8, gb, lat);
        check("w8_d",    32'(gd8), 32'hFF);
        check("w8_bout", 32'(gb),  32'd1);
        check("w8_lat",  32'(lat), 32'd8);
        prev8 = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            r  = int'(ra) - int'(rb) - int'(rc);
            run8(ra, rb, rc, prev8, gd8, gb, lat);
            check("rnd8_d",    32'(gd8), 32'(r[7:0]));
            check("rnd8_bout", 32'(gb),  32'(r < 0));
            check("rnd8_lat",  32'(lat), 32'd8);
            prev8 = r[7:0];
        end

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
